// File: rtl/gat_pkg.sv
// Shared types and constants for the GAT BRAM load bridge.
package gat_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DONE
  } gat_state_e;

  // Width of the per-cycle increment fed into the saturating debug counters.
  localparam int unsigned CNT_INC_W = 8;

endpackage

// File: rtl/gat_rd_pipe.sv
// Fixed-latency register slice for the host readback path.
module gat_rd_pipe #(
  parameter int W   = 32,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [LAT];

  always_ff @(posedge clk) begin
    // NOTE: pipeline stages are reset so rd_dout reads zero right after reset.
    if (rst) begin
      for (int i = 0; i < LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[LAT-1];

endmodule

// File: rtl/gat_bram_load_bridge.sv
// Host-load BRAM bridge: per-channel write forwarding, load/start/run/done sequencing,
// and a delayed readback path. Define GAT_BRAM_ADDR_CHECK_EN to enable word-address range checking.
module gat_bram_load_bridge
  import gat_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int TOP_WIDTH = 32,
  parameter  int CH_DATA_W = 20,
  parameter  int ADDR_W    = 20,
  parameter  int DEPTH     = 2**(ADDR_W-2),
  parameter  int OUT_W     = 32,
  parameter  int RD_LAT    = 2,
  localparam int WORD_W    = ADDR_W - 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH*TOP_WIDTH-1:0]   ld_din,
  input  logic [NUM_CH-1:0]             ld_ena,
  input  logic [NUM_CH-1:0]             ld_wea,
  input  logic [NUM_CH*ADDR_W-1:0]      ld_addra,
  input  logic [NUM_CH-1:0]             ld_done,
  output logic [NUM_CH-1:0]             core_we,
  output logic [NUM_CH*WORD_W-1:0]      core_addr,
  output logic [NUM_CH*CH_DATA_W-1:0]   core_din,
  output logic                          core_start,
  input  logic                          core_done,
  input  logic [ADDR_W-1:0]             rd_addrb,
  output logic [WORD_W-1:0]             core_rd_addr,
  input  logic [OUT_W-1:0]              core_rd_data,
  output logic [TOP_WIDTH-1:0]          rd_dout,
  output logic                          ready,
  output logic                          busy,
  output logic [TOP_WIDTH-1:0]          dbg_wr_cnt,
  output logic [TOP_WIDTH-1:0]          dbg_drop_cnt,
  output logic [NUM_CH-1:0]             err
);

  gat_state_e state_q, state_d;
  logic [NUM_CH-1:0] flags_q, flags_d;
  logic [NUM_CH-1:0] req, accept, drop, fwd, in_range;
  logic [WORD_W-1:0] waddr [NUM_CH];
  logic [CNT_INC_W-1:0] n_fwd, n_drop;
  logic [TOP_WIDTH:0] wr_sum, drop_sum;
  logic [TOP_WIDTH-1:0] wr_cnt_q, drop_cnt_q;
  logic [NUM_CH-1:0] core_we_q;
  logic [NUM_CH*WORD_W-1:0] core_addr_q;
  logic [NUM_CH*CH_DATA_W-1:0] core_din_q;
  logic open_st;
  logic unused_bits;

  assign req     = ld_ena & ld_wea;
  assign open_st = (state_q == ST_LOAD) || (state_q == ST_DONE);
  assign accept  = open_st ? req : '0;
  assign drop    = open_st ? '0 : req;

  // Byte-offset bits and upper host data bits are intentionally discarded.
  assign unused_bits = ^{ld_din, ld_addra, rd_addrb};

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      waddr[c]    = ld_addra[c*ADDR_W+2 +: WORD_W];
      in_range[c] = {1'b0, waddr[c]} < (WORD_W+1)'(DEPTH);
    end
  end

`ifdef GAT_BRAM_ADDR_CHECK_EN
  logic [NUM_CH-1:0] err_q;

  assign fwd = accept & in_range;

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_q | (accept & ~in_range);
  end

  assign err = err_q;
`else
  logic unused_range;

  assign fwd          = accept;
  assign unused_range = ^in_range;
  assign err          = '0;
`endif

  always_comb begin
    n_fwd  = '0;
    n_drop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      n_fwd  = n_fwd  + CNT_INC_W'(fwd[c]);
      n_drop = n_drop + CNT_INC_W'(drop[c]);
    end
  end

  assign wr_sum   = {1'b0, wr_cnt_q}   + (TOP_WIDTH+1)'(n_fwd);
  assign drop_sum = {1'b0, drop_cnt_q} + (TOP_WIDTH+1)'(n_drop);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    core_start = 1'b0;
    busy       = 1'b0;
    ready      = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        flags_d = flags_q | ld_done;
        if (&flags_d) state_d = ST_START;
      end
      ST_START: begin
        core_start = 1'b1;
        busy       = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (core_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        ready = 1'b1;
        if (|accept) begin
          state_d = ST_LOAD;
          flags_d = '0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      flags_q     <= '0;
      wr_cnt_q    <= '0;
      drop_cnt_q  <= '0;
      core_we_q   <= '0;
      core_addr_q <= '0;
      core_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      wr_cnt_q   <= wr_sum[TOP_WIDTH]   ? '1 : wr_sum[TOP_WIDTH-1:0];
      drop_cnt_q <= drop_sum[TOP_WIDTH] ? '1 : drop_sum[TOP_WIDTH-1:0];
      core_we_q  <= fwd;
      for (int c = 0; c < NUM_CH; c++) begin
        core_addr_q[c*WORD_W +: WORD_W]      <= waddr[c];
        core_din_q[c*CH_DATA_W +: CH_DATA_W] <= ld_din[c*TOP_WIDTH +: CH_DATA_W];
      end
    end
  end

  assign core_we      = core_we_q;
  assign core_addr    = core_addr_q;
  assign core_din     = core_din_q;
  assign dbg_wr_cnt   = wr_cnt_q;
  assign dbg_drop_cnt = drop_cnt_q;

  assign core_rd_addr = rd_addrb[ADDR_W-1:2];

  gat_rd_pipe #(
    .W   (TOP_WIDTH),
    .LAT (RD_LAT)
  ) u_rd_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (TOP_WIDTH'(core_rd_data)),
    .dout (rd_dout)
  );

endmodule

// File: tb/tb_gat_bram_load_bridge.sv
// Directed self-checking bench for gat_bram_load_bridge (DEPTH reduced to 16).
module tb_gat_bram_load_bridge;

  localparam int NC = 4;
  localparam int TW = 32;
  localparam int CW = 20;
  localparam int AW = 20;
  localparam int WW = AW - 2;
  localparam int OW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC*TW-1:0]  ld_din;
  logic [NC-1:0]     ld_ena, ld_wea, ld_done;
  logic [NC*AW-1:0]  ld_addra;
  logic [NC-1:0]     core_we;
  logic [NC*WW-1:0]  core_addr;
  logic [NC*CW-1:0]  core_din;
  logic              core_start, core_done;
  logic [AW-1:0]     rd_addrb;
  logic [WW-1:0]     core_rd_addr;
  logic [OW-1:0]     core_rd_data;
  logic [TW-1:0]     rd_dout;
  logic              ready, busy;
  logic [TW-1:0]     dbg_wr_cnt, dbg_drop_cnt;
  logic [NC-1:0]     err;

  int n_cmp = 0;
  int n_err = 0;

  gat_bram_load_bridge #(
    .NUM_CH(NC), .TOP_WIDTH(TW), .CH_DATA_W(CW), .ADDR_W(AW),
    .DEPTH(16), .OUT_W(OW), .RD_LAT(2)
  ) dut (
    .clk(clk), .rst(rst), .ld_din(ld_din), .ld_ena(ld_ena), .ld_wea(ld_wea),
    .ld_addra(ld_addra), .ld_done(ld_done), .core_we(core_we),
    .core_addr(core_addr), .core_din(core_din), .core_start(core_start),
    .core_done(core_done), .rd_addrb(rd_addrb), .core_rd_addr(core_rd_addr),
    .core_rd_data(core_rd_data), .rd_dout(rd_dout), .ready(ready), .busy(busy),
    .dbg_wr_cnt(dbg_wr_cnt), .dbg_drop_cnt(dbg_drop_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ld_din    = '0;
    ld_ena    = '0;
    ld_wea    = '0;
    ld_addra  = '0;
    ld_done   = '0;
    core_done = 1'b0;
  endtask

  task automatic set_write(input int ch, input logic [AW-1:0] addr, input logic [TW-1:0] data);
    ld_ena[ch]              = 1'b1;
    ld_wea[ch]              = 1'b1;
    ld_addra[ch*AW +: AW]   = addr;
    ld_din[ch*TW +: TW]     = data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    rd_addrb     = '0;
    core_rd_data = '0;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({ready, busy, core_start} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags got %b want 000", {ready, busy, core_start});
    end
    n_cmp++;
    if (core_we !== 4'b0000 || err !== 4'b0000) begin
      n_err++; $display("FAIL reset_we_err got we=%b err=%b want 0000/0000", core_we, err);
    end
    n_cmp++;
    if (dbg_wr_cnt !== 32'd0 || dbg_drop_cnt !== 32'd0 || rd_dout !== 32'd0) begin
      n_err++; $display("FAIL reset_cnt got wr=%0d drop=%0d rd=%h want 0/0/0", dbg_wr_cnt, dbg_drop_cnt, rd_dout);
    end
  endtask

  task automatic test_write();
    set_write(0, 20'h00010, 32'hFFFA_BCDE);
    tick();
    clear_inputs();
    n_cmp++;
    if (core_we !== 4'b0001) begin
      n_err++; $display("FAIL wr_we got %b want 0001", core_we);
    end
    n_cmp++;
    if (core_addr[0 +: WW] !== 18'd4 || core_din[0 +: CW] !== 20'hABCDE) begin
      n_err++; $display("FAIL wr_data got addr=%h din=%h want 4/abcde", core_addr[0 +: WW], core_din[0 +: CW]);
    end
    n_cmp++;
    if (dbg_wr_cnt !== 32'd1) begin
      n_err++; $display("FAIL wr_cnt got %0d want 1", dbg_wr_cnt);
    end
    // Two channels at once with a byte offset; ch2 has wea without ena.
    set_write(1, 20'h0001F, 32'h0000_0111);
    set_write(3, 20'h00034, 32'h0000_0333);
    ld_wea[2] = 1'b1;
    tick();
    clear_inputs();
    n_cmp++;
    if (core_we !== 4'b1010) begin
      n_err++; $display("FAIL wr2_we got %b want 1010", core_we);
    end
    n_cmp++;
    if (core_addr[1*WW +: WW] !== 18'd7 || core_addr[3*WW +: WW] !== 18'd13 || core_din[3*CW +: CW] !== 20'h00333) begin
      n_err++; $display("FAIL wr2_data got a1=%0d a3=%0d d3=%h want 7/13/333",
                        core_addr[1*WW +: WW], core_addr[3*WW +: WW], core_din[3*CW +: CW]);
    end
    n_cmp++;
    if (dbg_wr_cnt !== 32'd3) begin
      n_err++; $display("FAIL wr2_cnt got %0d want 3", dbg_wr_cnt);
    end
    tick();
    n_cmp++;
    if (core_we !== 4'b0000) begin
      n_err++; $display("FAIL wr_idle got %b want 0000", core_we);
    end
  endtask

  task automatic test_fsm();
    core_done = 1'b1;
    tick();
    clear_inputs();
    n_cmp++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL done_in_load got ready=%b busy=%b want 0/0", ready, busy);
    end
    ld_done = 4'b0111;
    tick();
    clear_inputs();
    tick();
    n_cmp++;
    if (busy !== 1'b0 || core_start !== 1'b0) begin
      n_err++; $display("FAIL partial_done got busy=%b start=%b want 0/0", busy, core_start);
    end
    // Last done flag arrives together with a write on the same channel.
    ld_done = 4'b1000;
    set_write(3, 20'h00008, 32'h0000_0055);
    tick();
    clear_inputs();
    n_cmp++;
    if (core_start !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL start got start=%b busy=%b want 1/1", core_start, busy);
    end
    n_cmp++;
    if (core_we !== 4'b1000 || dbg_wr_cnt !== 32'd4) begin
      n_err++; $display("FAIL done_write got we=%b cnt=%0d want 1000/4", core_we, dbg_wr_cnt);
    end
    tick();
    n_cmp++;
    if (core_start !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL run got start=%b busy=%b want 0/1", core_start, busy);
    end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 3; i++) begin
      set_write(1, 20'h00004, 32'h0000_0999);
      tick();
      clear_inputs();
      n_cmp++;
      if (core_we !== 4'b0000) begin
        n_err++; $display("FAIL drop_we[%0d] got %b want 0000", i, core_we);
      end
    end
    n_cmp++;
    if (dbg_drop_cnt !== 32'd3 || dbg_wr_cnt !== 32'd4) begin
      n_err++; $display("FAIL drop_cnt got drop=%0d wr=%0d want 3/4", dbg_drop_cnt, dbg_wr_cnt);
    end
    core_done = 1'b1;
    tick();
    clear_inputs();
    n_cmp++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL to_done got ready=%b busy=%b want 1/0", ready, busy);
    end
    tick();
    n_cmp++;
    if (ready !== 1'b1) begin
      n_err++; $display("FAIL hold_done got ready=%b want 1", ready);
    end
  endtask

  task automatic test_done_write();
    set_write(2, 20'h00008, 32'h0001_2345);
    tick();
    clear_inputs();
    n_cmp++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL leave_done got ready=%b busy=%b want 0/0", ready, busy);
    end
    n_cmp++;
    if (core_we !== 4'b0100 || core_addr[2*WW +: WW] !== 18'd2 || core_din[2*CW +: CW] !== 20'h12345) begin
      n_err++; $display("FAIL done_fwd got we=%b a=%0d d=%h want 0100/2/12345",
                        core_we, core_addr[2*WW +: WW], core_din[2*CW +: CW]);
    end
    n_cmp++;
    if (dbg_wr_cnt !== 32'd5) begin
      n_err++; $display("FAIL done_cnt got %0d want 5", dbg_wr_cnt);
    end
    // Flags must have been cleared: one channel's done alone cannot start the core.
    ld_done = 4'b1000;
    tick();
    clear_inputs();
    tick();
    n_cmp++;
    if (busy !== 1'b0 || core_start !== 1'b0) begin
      n_err++; $display("FAIL flags_clr got busy=%b start=%b want 0/0", busy, core_start);
    end
  endtask

  task automatic test_read();
    rd_addrb     = 20'h00020;
    core_rd_data = 32'h0000_1234;
    #1;
    n_cmp++;
    if (core_rd_addr !== 18'd8) begin
      n_err++; $display("FAIL rd_addr got %0d want 8", core_rd_addr);
    end
    tick();
    core_rd_data = 32'h0000_5678;
    n_cmp++;
    if (rd_dout !== 32'h0) begin
      n_err++; $display("FAIL rd_lat1 got %h want 0", rd_dout);
    end
    tick();
    n_cmp++;
    if (rd_dout !== 32'h0000_1234) begin
      n_err++; $display("FAIL rd_lat2 got %h want 1234", rd_dout);
    end
    tick();
    n_cmp++;
    if (rd_dout !== 32'h0000_5678) begin
      n_err++; $display("FAIL rd_next got %h want 5678", rd_dout);
    end
  endtask

  task automatic test_addr_check();
    set_write(0, 20'h00040, 32'h0000_0077);
    tick();
    clear_inputs();
`ifdef GAT_BRAM_ADDR_CHECK_EN
    n_cmp++;
    if (core_we !== 4'b0000 || err !== 4'b0001 || dbg_wr_cnt !== 32'd5) begin
      n_err++; $display("FAIL oob got we=%b err=%b cnt=%0d want 0000/0001/5", core_we, err, dbg_wr_cnt);
    end
`else
    n_cmp++;
    if (core_we !== 4'b0001 || core_addr[0 +: WW] !== 18'd16 || err !== 4'b0000 || dbg_wr_cnt !== 32'd6) begin
      n_err++; $display("FAIL oob got we=%b a=%0d err=%b cnt=%0d want 0001/16/0000/6",
                        core_we, core_addr[0 +: WW], err, dbg_wr_cnt);
    end
`endif
    set_write(0, 20'h0003C, 32'h0000_0088);
    tick();
    clear_inputs();
    n_cmp++;
    if (core_we !== 4'b0001 || core_addr[0 +: WW] !== 18'd15) begin
      n_err++; $display("FAIL in_range got we=%b a=%0d want 0001/15", core_we, core_addr[0 +: WW]);
    end
  endtask

  task automatic test_reset_mid_run();
    ld_done = 4'b1111;
    tick();
    clear_inputs();
    tick();
    n_cmp++;
    if (busy !== 1'b1 || core_start !== 1'b0) begin
      n_err++; $display("FAIL mid_run got busy=%b start=%b want 1/0", busy, core_start);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || ready !== 1'b0 || err !== 4'b0000 || rd_dout !== 32'h0) begin
      n_err++; $display("FAIL run_reset got busy=%b ready=%b err=%b rd=%h want 0/0/0000/0", busy, ready, err, rd_dout);
    end
    n_cmp++;
    if (dbg_wr_cnt !== 32'd0 || dbg_drop_cnt !== 32'd0) begin
      n_err++; $display("FAIL run_reset_cnt got wr=%0d drop=%0d want 0/0", dbg_wr_cnt, dbg_drop_cnt);
    end
    ld_done = 4'b0001;
    tick();
    clear_inputs();
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL post_reset_load got busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_fsm();
    test_drop();
    test_done_write();
    test_read();
    test_addr_check();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gat_bram_load_bridge.md
GAT_BRAM_LOAD_BRIDGE -- requirements
Module: gat_bram_load_bridge

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent host-load BRAM channels.
REQ-002 SHALL have parameter TOP_WIDTH, default 32: host data bus width.
REQ-003 SHALL have parameter CH_DATA_W, default 20: core write data width per channel; CH_DATA_W <= TOP_WIDTH.
REQ-004 SHALL have parameter ADDR_W, default 20: host byte-address width; word address width WORD_W = ADDR_W-2.
REQ-005 SHALL have parameter DEPTH, default 2**(ADDR_W-2): valid words per channel.
REQ-006 SHALL have parameter OUT_W, default 32: core readback width; OUT_W <= TOP_WIDTH.
REQ-007 SHALL have parameter RD_LAT, default 2: readback register stages, >= 1.
REQ-008 SHALL have one clock and a synchronous active-high reset; ports: clk input 1, rising-edge clock.
REQ-009 rst input 1, synchronous active-high reset.
REQ-010 ld_din input NUM_CH*TOP_WIDTH, host write data, channel c in slice c.
REQ-011 ld_ena input NUM_CH, per-channel host enable.
REQ-012 ld_wea input NUM_CH, per-channel host write enable.
REQ-013 ld_addra input NUM_CH*ADDR_W, per-channel host byte address.
REQ-014 ld_done input NUM_CH, per-channel load-done level/pulse from register bank.
REQ-015 core_we output NUM_CH; core_addr output NUM_CH*WORD_W; core_din output NUM_CH*CH_DATA_W: core-side writes.
REQ-016 core_start output 1, one-cycle start pulse; core_done input 1, core completion pulse.
REQ-017 rd_addrb input ADDR_W, host byte read address; core_rd_addr output WORD_W; core_rd_data input OUT_W; rd_dout output TOP_WIDTH.
REQ-018 ready output 1, result available; busy output 1, core running; dbg_wr_cnt output TOP_WIDTH; dbg_drop_cnt output TOP_WIDTH; err output NUM_CH (see Configuration).

Function
REQ-019 FSM states LOAD, START, RUN, DONE; reset state LOAD.
REQ-020 LOAD: per-channel sticky flag set when ld_done[c]=1; when all flags set (including same-cycle) -> START.
REQ-021 START: core_start=1 for exactly one cycle, then RUN; busy=1 in START and RUN.
REQ-022 RUN: on core_done=1 -> DONE; core_done in other states ignored.
REQ-023 DONE: ready=1; first accepted host write (ena&wea on any channel) -> LOAD, clears all sticky flags, ready=0 next cycle, and that write is forwarded.
REQ-024 Write accepted when ld_ena[c]&ld_wea[c] in LOAD or DONE; forwarded 1 cycle later: core_we[c]=1, core_addr=ld_addra[ADDR_W-1:2], core_din=ld_din[CH_DATA_W-1:0]; byte-offset bits [1:0] ignored.
REQ-025 Writes in START/RUN dropped (core_we=0), dbg_drop_cnt += number of dropped channel writes that cycle.
REQ-026 dbg_wr_cnt += number of accepted channel writes per cycle; both counters saturate at all-ones.
REQ-027 Write and ld_done same cycle, same channel: write forwarded and flag set.
REQ-028 core_rd_addr = rd_addrb[ADDR_W-1:2] combinationally; rd_dout = core_rd_data zero-extended, delayed RD_LAT cycles; read path active in all states.

Reset
REQ-029 Reset (including mid-RUN) -> LOAD; flags, counters, pipelines, core_we, core_start, ready, busy, err, rd_dout all 0.

Configuration
REQ-030 Macro GAT_BRAM_ADDR_CHECK_EN defined: accepted write with word address >= DEPTH is not forwarded (core_we=0) and sets sticky err[c] until reset; not counted in dbg_wr_cnt.
REQ-031 Macro undefined: no range check, address truncated to WORD_W, err tied 0.

Structure
REQ-032 Shared package gat_pkg holds FSM state enum and saturating-counter width constant.
REQ-033 Sub-module gat_rd_pipe: RD_LAT-deep register slice for the readback path.

Verification
REQ-034 Reset, write ch0 addr 0x10 data 0xABCDE -> next cycle core_we[0]=1, core_addr[0]=4, core_din[0]=0xABCDE, dbg_wr_cnt=1.
REQ-035 ld_done asserted on ch0..2 only -> stays LOAD; ch3 done -> one core_start pulse, busy=1; core_done -> ready=1.
REQ-036 Writes on ch1 during RUN x3 -> core_we[1]=0, dbg_drop_cnt=3.
REQ-037 In DONE, write ch2 -> ready=0, state LOAD, flags cleared, write forwarded.
REQ-038 rd_addrb=0x20, core_rd_data=0x1234 -> core_rd_addr=8, rd_dout=0x1234 after RD_LAT=2 cycles.
REQ-039 With GAT_BRAM_ADDR_CHECK_EN, DEPTH=16, write addr 0x40 -> no core_we, err[c]=1; reset during RUN -> LOAD, err=0.
